// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller and its datapath:
// state codes, opcode constants, instruction classes and mux select codes.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Bit positions of the one-hot instruction class vector
    localparam int NUM_CLS   = 9;
    localparam int CLS_R     = 0;
    localparam int CLS_I     = 1;
    localparam int CLS_LOAD  = 2;
    localparam int CLS_STORE = 3;
    localparam int CLS_BR    = 4;
    localparam int CLS_JAL   = 5;
    localparam int CLS_JALR  = 6;
    localparam int CLS_LUI   = 7;
    localparam int CLS_AUIPC = 8;

    typedef logic [NUM_CLS-1:0] op_cls_t;

    localparam logic [6:0] CLS_OPCODE [NUM_CLS] = '{
        OP_RTYPE, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH,
        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
    };

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_RS1   = 2'd1;
    localparam logic [1:0] SRCA_OLDPC = 2'd2;

    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_CMP    = 2'd1;
    localparam logic [1:0] ALU_FUNCT  = 2'd2;

    localparam logic       PCSRC_ALU    = 1'b0;
    localparam logic       PCSRC_ALUOUT = 1'b1;

    localparam logic [1:0] WD_ALUOUT  = 2'd0;
    localparam logic [1:0] WD_MDR     = 2'd1;
    localparam logic [1:0] WD_PC4     = 2'd2;

endpackage

// File: rtl/mc_ctrl_if.sv
// Memory handshake between the controller (master) and the memory port (slave).
interface mc_ctrl_if;
    logic       mem_req;
    logic       mem_we;
    logic       mem_ready;
    logic [2:0] DMType;

    modport master (output mem_req, output mem_we, output DMType, input mem_ready);
    modport slave  (input mem_req, input mem_we, input DMType, output mem_ready);
endinterface

// File: rtl/mc_opclass.sv
// Combinational opcode classifier: one-hot class vector plus a legal bit.
module mc_opclass
    import mc_pkg::*;
(
    input  logic [6:0] Op,
    output op_cls_t    op_cls,
    output logic       legal
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLS; gi++) begin : g_match
            assign op_cls[gi] = (Op == CLS_OPCODE[gi]);
        end
    endgenerate

    assign legal = |op_cls;

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle RV32-style controller: FETCH/DECODE/EXEC/MEM/WB FSM with a
// sticky illegal-opcode trap and a request/ready memory handshake.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    mc_ctrl_if.master   mem,
    input  logic [6:0]  Op,
    input  logic [2:0]  Funct3,
    input  logic        Zero,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUCls,
    output logic        PCSrc,
    output logic [1:0]  WDSel,
    output logic        illegal,
    output logic [2:0]  state
);

    state_t  state_reg, state_next;
    op_cls_t cls_reg;
    op_cls_t op_cls;
    logic    op_legal;
    logic    illegal_reg;

    logic req_c, we_c, irw_c, pcw_c, rw_c;

    mc_opclass u_opclass (
        .Op     (Op),
        .op_cls (op_cls),
        .legal  (op_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_FETCH;
            cls_reg     <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            // IR is stable from DECODE on; latching the class keeps later states independent of Op
            if (state_reg == ST_DECODE)
                cls_reg <= op_cls;
            if (state_next == ST_TRAP)
                illegal_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_c      = 1'b0;
        we_c       = 1'b0;
        irw_c      = 1'b0;
        pcw_c      = 1'b0;
        rw_c       = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ALUCls     = ALU_ADD;
        PCSrc      = PCSRC_ALU;
        WDSel      = WD_ALUOUT;
        mem.DMType = 3'd0;

        case (state_reg)
            ST_FETCH: begin
                req_c   = 1'b1;
                ALUSrcA = SRCA_PC;
                ALUSrcB = SRCB_FOUR;
                PCSrc   = PCSRC_ALU;
                if (mem.mem_ready) begin
                    irw_c      = 1'b1;
                    pcw_c      = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_IMM;
                ALUCls     = ALU_ADD;
                state_next = op_legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                state_next = ST_WB;
                if (cls_reg[CLS_R]) begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_RS2;
                    ALUCls  = ALU_FUNCT;
                end else if (cls_reg[CLS_I]) begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ALUCls  = ALU_FUNCT;
                end else if (cls_reg[CLS_LOAD] || cls_reg[CLS_STORE]) begin
                    ALUSrcA    = SRCA_RS1;
                    ALUSrcB    = SRCB_IMM;
                    ALUCls     = ALU_ADD;
                    state_next = ST_MEM;
                end else if (cls_reg[CLS_BR]) begin
                    ALUSrcA    = SRCA_RS1;
                    ALUSrcB    = SRCB_RS2;
                    ALUCls     = ALU_CMP;
                    pcw_c      = Zero;
                    PCSrc      = PCSRC_ALUOUT;
                    state_next = ST_FETCH;
                end else if (cls_reg[CLS_JAL]) begin
                    // jal target was computed in DECODE and sits in ALUOut
                    pcw_c = 1'b1;
                    PCSrc = PCSRC_ALUOUT;
                end else if (cls_reg[CLS_JALR]) begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ALUCls  = ALU_ADD;
                    pcw_c   = 1'b1;
                    PCSrc   = PCSRC_ALU;
                end else begin
                    ALUSrcA = cls_reg[CLS_AUIPC] ? SRCA_OLDPC : SRCA_PC;
                    ALUSrcB = SRCB_IMM;
                    ALUCls  = ALU_ADD;
                end
            end
            ST_MEM: begin
                req_c      = 1'b1;
                we_c       = cls_reg[CLS_STORE];
                mem.DMType = Funct3;
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                if (mem.mem_ready)
                    state_next = cls_reg[CLS_STORE] ? ST_FETCH : ST_WB;
            end
            ST_WB: begin
                rw_c       = 1'b1;
                state_next = ST_FETCH;
                if (cls_reg[CLS_LOAD])
                    WDSel = WD_MDR;
                else if (cls_reg[CLS_JAL] || cls_reg[CLS_JALR])
                    WDSel = WD_PC4;
                else
                    WDSel = WD_ALUOUT;
            end
            ST_TRAP: begin
                state_next = ST_TRAP;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    // Enables are forced low while reset is held so an interrupted access cannot write
    assign mem.mem_req = req_c & ~rst;
    assign mem.mem_we  = we_c  & ~rst;
    assign IRWrite     = irw_c & ~rst;
    assign PCWrite     = pcw_c & ~rst;
    assign RegWrite    = rw_c  & ~rst;
    assign illegal     = illegal_reg;
    assign state       = state_reg;

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The module SHALL have the following ports, clock and reset first.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- Op  in  7  opcode from the instruction register (IR).
- Funct3  in  3  funct3 from IR.
- Zero  in  1  ALU condition flag; 1 = branch condition true.
- mem_ready  in  1  memory handshake acknowledge.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  memory write qualifier.
- IRWrite  out  1  IR load enable.
- PCWrite  out  1  PC load enable.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  2  ALU A select: 0 = PC, 1 = rs1, 2 = old PC.
- ALUSrcB  out  2  ALU B select: 0 = rs2, 1 = imm, 2 = constant 4.
- ALUCls  out  2  ALU class: 0 = add, 1 = compare, 2 = funct-decoded.
- PCSrc  out  1  PC source: 0 = ALU result, 1 = ALUOut register.
- WDSel  out  2  write-data select: 0 = ALUOut, 1 = MDR, 2 = PC+4.
- DMType  out  3  memory access size code; Funct3 passed through during MEM.
- illegal  out  1  sticky illegal-opcode flag.
- state  out  3  current state, exported for debug.

Function
REQ-002 The state machine SHALL have these states and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7.
REQ-003 FETCH SHALL assert mem_req = 1 and mem_we = 0, and remain in FETCH while mem_ready = 0.
REQ-004 When mem_ready = 1 in FETCH, the controller SHALL assert IRWrite = 1, assert PCWrite = 1 with ALUSrcA = 0, ALUSrcB = 2, PCSrc = 0, and go to DECODE.
REQ-005 DECODE SHALL compute the branch target (ALUSrcA = 2, ALUSrcB = 1, ALUCls = 0) and classify Op.
REQ-006 From DECODE, the controller SHALL go to EXEC for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111 and 0010111, and to TRAP for any other opcode.
REQ-007 EXEC SHALL drive the following per class.
- R-type: ALUSrcA = 1, ALUSrcB = 0, ALUCls = 2.
- I-ALU: ALUSrcB = 1, ALUCls = 2.
- Load/store: ALUSrcB = 1, ALUCls = 0.
- Branch: ALUCls = 1; PCWrite = Zero, PCSrc = 1; then go to FETCH.
- jal/jalr: PCWrite = 1 with the target, then go to WB.
- lui/auipc: ALUSrcB = 1, ALUCls = 0.
REQ-008 After EXEC, loads and stores SHALL go to MEM; all other non-branch classes SHALL go to WB.
REQ-009 MEM SHALL assert mem_req = 1, drive mem_we = 1 for stores only, and drive DMType = Funct3.
REQ-010 MEM SHALL hold its outputs stable until mem_ready = 1; then a store SHALL go to FETCH and a load SHALL go to WB.
REQ-011 WB SHALL assert RegWrite = 1 for exactly one cycle with WDSel = 1 for loads, 2 for jal/jalr and 0 otherwise, then go to FETCH.
REQ-012 Instruction latency SHALL be, with zero-wait memory: branch 3 cycles, ALU/jump 4, store 4, load 5; each mem_ready = 0 cycle SHALL add one cycle.
REQ-013 mem_ready SHALL be ignored outside FETCH and MEM.
REQ-014 A mem_ready = 1 in the first cycle of a request SHALL complete that request in that cycle.
REQ-015 TRAP SHALL set illegal = 1, hold all enables at 0, and remain in TRAP until rst.
REQ-016 Outside the cycles specified above, every enable (IRWrite, PCWrite, RegWrite, mem_req, mem_we) SHALL be 0.

Reset
REQ-017 With rst = 1 at a clock edge, the next state SHALL be FETCH, illegal SHALL be 0, and every output enable SHALL be 0 during reset cycles.
REQ-018 A reset asserted mid-MEM or mid-FETCH SHALL drop mem_req in the cycle after the edge, and no write side effect of the interrupted instruction SHALL occur after reset.
REQ-019 The first cycle after reset deasserts SHALL be FETCH with mem_req = 1.

Structure
REQ-020 State encodings, opcode constants and the ALUSrc/WDSel/ALUCls codes SHALL live in a shared package, mc_pkg, for use by the datapath.
REQ-021 Opcode classification SHALL be a combinational sub-module, mc_opclass, that maps Op to a one-hot class vector and a legal bit.
REQ-022 The FSM and output logic SHALL be contained in mc_ctrl.

Verification
REQ-023 The bench SHALL cover the following directed scenarios.
- add (Op 0110011), mem_ready always 1: states 0,1,2,4,0; RegWrite = 1 only in cycle 4 with WDSel = 0.
- lw (Op 0000011, Funct3 010), mem_ready low 2 cycles in MEM: MEM lasts 3 cycles, DMType = 010, then WB with WDSel = 1; total 7 cycles.
- beq with Zero = 1, then with Zero = 0: PCWrite = 1 with PCSrc = 1 in EXEC for the first only; both return to FETCH after 3 cycles.
- sw with mem_ready = 1 immediately: mem_we = 1 for 1 cycle and RegWrite never asserted.
- Op 0000000 fetched: TRAP entered after DECODE, illegal = 1 and all enables 0 for 20 cycles; rst pulse then returns to FETCH with illegal = 0.
- rst asserted during a stalled FETCH: mem_req = 0 next cycle, and state = 0 after rst release with mem_req = 1.
